// File: rtl/crop_config_sched.sv
// Crop window scheduler. CFG_* writes are held in a shadow register and
// committed only in vertical blanking. The active frame size is measured
// from DE/VSYNC. Define CROP_CLAMP_EN to clamp out-of-frame windows
// instead of rejecting them.
module crop_config_sched (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        DE_IN,
  input  logic        VSYNC_POS_IN,
  input  logic        HSYNC_POS_IN,
  input  logic        CFG_VALID,
  output logic        CFG_READY,
  input  logic        CFG_EN,
  input  logic [15:0] CFG_START_X,
  input  logic [15:0] CFG_START_Y,
  input  logic [15:0] CFG_WIDTH,
  input  logic [15:0] CFG_HEIGHT,
  output logic        CROP_EN,
  output logic [15:0] CROP_START_X,
  output logic [15:0] CROP_START_Y,
  output logic [15:0] CROP_WIDTH,
  output logic [15:0] CROP_HEIGHT,
  output logic [15:0] FRAME_WIDTH,
  output logic [15:0] FRAME_HEIGHT,
  output logic        MEAS_VALID,
  output logic        PENDING,
  output logic        CFG_ERR
);

  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, COMMIT = 2'd2} state_t;

  typedef struct packed {
    logic        en;
    logic [15:0] start_x;
    logic [15:0] start_y;
    logic [15:0] width;
    logic [15:0] height;
  } win_t;

  state_t      state_q, state_nxt;
  win_t        shadow_q, crop_q, commit_win;
  logic        vs_prev, de_prev;
  logic        vs_fall, vs_rise, de_fall, de_rise;
  logic        cfg_fire, ready_q, err_q, meas_q;
  logic        win_ok, commit_load, pending_c;
  logic [15:0] pix_cnt, line_cnt, frame_w_q, frame_h_q;
  logic [16:0] end_x, end_y;
  logic        unused_hsync;

  // HSYNC is monitored only; line boundaries are taken from DE.
  assign unused_hsync = HSYNC_POS_IN;

  assign vs_fall  = ~VSYNC_POS_IN & vs_prev;
  assign vs_rise  =  VSYNC_POS_IN & ~vs_prev;
  assign de_fall  = ~DE_IN & de_prev;
  assign de_rise  =  DE_IN & ~de_prev;
  assign cfg_fire = CFG_VALID & ready_q;

`ifdef CROP_CLAMP_EN
  // Returns {clamped_start, clamped_size} for one axis.
  function automatic logic [31:0] clamp_axis(input logic [15:0] start,
                                             input logic [15:0] size,
                                             input logic [15:0] frame);
    logic [15:0] s;
    logic [16:0] e;
    s = (start >= frame) ? ((frame == 16'd0) ? 16'd0 : frame - 16'd1) : start;
    e = {1'b0, s} + {1'b0, size};
    return {s, (e > {1'b0, frame}) ? frame - s : size};
  endfunction
`endif

  always_ff @(posedge CLK) begin
    // NOTE: synchronous reset; state and ready use non-blocking assignment so every reader sees the pre-edge value.
    if (!RST_N) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_nxt;
      ready_q <= (state_nxt != COMMIT);
    end
  end

  always_comb begin
    // NOTE: default first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (cfg_fire) state_nxt = vs_fall ? COMMIT : PEND;
      PEND:    if (vs_fall)  state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pending_c  = (state_q == PEND) || (state_q == COMMIT);
    // 17-bit sums so a start near 65535 cannot wrap into range.
    end_x      = {1'b0, shadow_q.start_x} + {1'b0, shadow_q.width};
    end_y      = {1'b0, shadow_q.start_y} + {1'b0, shadow_q.height};
    win_ok     = ~shadow_q.en | ~meas_q |
                 ((end_x <= {1'b0, frame_w_q}) & (end_y <= {1'b0, frame_h_q}));
    commit_win = shadow_q;
`ifdef CROP_CLAMP_EN
    commit_load = 1'b1;
    if (!win_ok) begin
      {commit_win.start_x, commit_win.width}  =
        clamp_axis(shadow_q.start_x, shadow_q.width, frame_w_q);
      {commit_win.start_y, commit_win.height} =
        clamp_axis(shadow_q.start_y, shadow_q.height, frame_h_q);
    end
`else
    commit_load = win_ok;
`endif
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      vs_prev   <= 1'b0;
      de_prev   <= 1'b0;
      pix_cnt   <= '0;
      line_cnt  <= '0;
      frame_w_q <= '0;
      frame_h_q <= '0;
      meas_q    <= 1'b0;
      shadow_q  <= '0;
      crop_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      vs_prev <= VSYNC_POS_IN;
      de_prev <= DE_IN;

      if (de_fall) begin
        frame_w_q <= pix_cnt;
        pix_cnt   <= '0;
      end else if (DE_IN) begin
        pix_cnt <= pix_cnt + 16'd1;
      end

      // A line starting on the vs_rise cycle belongs to the new frame.
      if (vs_rise) begin
        frame_h_q <= line_cnt;
        line_cnt  <= de_rise ? 16'd1 : 16'd0;
        if (line_cnt != 16'd0) meas_q <= 1'b1;
      end else if (de_rise) begin
        line_cnt <= line_cnt + 16'd1;
      end

      if (cfg_fire)
        shadow_q <= '{en: CFG_EN, start_x: CFG_START_X, start_y: CFG_START_Y,
                      width: CFG_WIDTH, height: CFG_HEIGHT};

      err_q <= 1'b0;
      if (state_q == COMMIT) begin
        if (commit_load) crop_q <= commit_win;
        err_q <= ~win_ok;
      end
    end
  end

  assign CFG_READY    = ready_q;
  assign CROP_EN      = crop_q.en;
  assign CROP_START_X = crop_q.start_x;
  assign CROP_START_Y = crop_q.start_y;
  assign CROP_WIDTH   = crop_q.width;
  assign CROP_HEIGHT  = crop_q.height;
  assign FRAME_WIDTH  = frame_w_q;
  assign FRAME_HEIGHT = frame_h_q;
  assign MEAS_VALID   = meas_q;
  assign PENDING      = pending_c;
  assign CFG_ERR      = err_q;

endmodule

// File: tb/tb_crop_config_sched.sv
// Directed bench for crop_config_sched; expectations follow the CROP_CLAMP_EN
// setting of the build.
module tb_crop_config_sched;

  logic        CLK, RST_N, DE_IN, VSYNC_POS_IN, HSYNC_POS_IN;
  logic        CFG_VALID, CFG_READY, CFG_EN;
  logic [15:0] CFG_START_X, CFG_START_Y, CFG_WIDTH, CFG_HEIGHT;
  logic        CROP_EN;
  logic [15:0] CROP_START_X, CROP_START_Y, CROP_WIDTH, CROP_HEIGHT;
  logic [15:0] FRAME_WIDTH, FRAME_HEIGHT;
  logic        MEAS_VALID, PENDING, CFG_ERR;

  int n_checks = 0;
  int n_errors = 0;

`ifdef CROP_CLAMP_EN
  localparam int E6_SX = 1900, E6_SY = 0,   E6_W = 20,  E6_H = 10;
  localparam int E7_SX = 1919, E7_SY = 0,   E7_W = 1,   E7_H = 10;
`else
  localparam int E6_SX = 200,  E6_SY = 100, E6_W = 320, E6_H = 240;
  localparam int E7_SX = 200,  E7_SY = 100, E7_W = 320, E7_H = 240;
`endif

  crop_config_sched dut (
    .CLK(CLK), .RST_N(RST_N), .DE_IN(DE_IN), .VSYNC_POS_IN(VSYNC_POS_IN),
    .HSYNC_POS_IN(HSYNC_POS_IN), .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY),
    .CFG_EN(CFG_EN), .CFG_START_X(CFG_START_X), .CFG_START_Y(CFG_START_Y),
    .CFG_WIDTH(CFG_WIDTH), .CFG_HEIGHT(CFG_HEIGHT), .CROP_EN(CROP_EN),
    .CROP_START_X(CROP_START_X), .CROP_START_Y(CROP_START_Y),
    .CROP_WIDTH(CROP_WIDTH), .CROP_HEIGHT(CROP_HEIGHT),
    .FRAME_WIDTH(FRAME_WIDTH), .FRAME_HEIGHT(FRAME_HEIGHT),
    .MEAS_VALID(MEAS_VALID), .PENDING(PENDING), .CFG_ERR(CFG_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check_crop(input string tag, input int en, input int sx,
                            input int sy, input int w, input int h);
    check({tag, ".en"}, CROP_EN, en);
    check({tag, ".sx"}, CROP_START_X, sx);
    check({tag, ".sy"}, CROP_START_Y, sy);
    check({tag, ".w"},  CROP_WIDTH, w);
    check({tag, ".h"},  CROP_HEIGHT, h);
  endtask

  task automatic cfg_write(input logic en, input logic [15:0] sx, input logic [15:0] sy,
                           input logic [15:0] w, input logic [15:0] h);
    check("wr_ready", CFG_READY, 1);
    CFG_EN = en; CFG_START_X = sx; CFG_START_Y = sy; CFG_WIDTH = w; CFG_HEIGHT = h;
    CFG_VALID = 1'b1;
    tick(1);
    CFG_VALID = 1'b0;
  endtask

  task automatic short_lines(input int n);
    repeat (n) begin
      DE_IN = 1'b1; tick(1);
      DE_IN = 1'b0; tick(1);
    end
  endtask

  task automatic long_line(input int w);
    DE_IN = 1'b1; tick(w);
    DE_IN = 1'b0; tick(2);
  endtask

  // 1080 lines; only the final line is 1920 wide, and that one sets FRAME_WIDTH.
  task automatic full_frame();
    short_lines(1079);
    long_line(1920);
  endtask

  // Leaves the bench just after the edge that samples VSYNC low (COMMIT cycle).
  task automatic vs_to_commit();
    VSYNC_POS_IN = 1'b1; tick(3);
    VSYNC_POS_IN = 1'b0; tick(1);
  endtask

  initial begin
    RST_N = 1'b0; DE_IN = 1'b0; VSYNC_POS_IN = 1'b0; HSYNC_POS_IN = 1'b0;
    CFG_VALID = 1'b0; CFG_EN = 1'b0;
    CFG_START_X = '0; CFG_START_Y = '0; CFG_WIDTH = '0; CFG_HEIGHT = '0;
    tick(3);
    check("rst.ready", CFG_READY, 0);
    check("rst.pending", PENDING, 0);
    check("rst.meas", MEAS_VALID, 0);
    check("rst.fw", FRAME_WIDTH, 0);
    check("rst.err", CFG_ERR, 0);
    check_crop("rst", 0, 0, 0, 0, 0);
    RST_N = 1'b1;
    tick(1);
    check("rst.ready_after", CFG_READY, 1);

    // Before measurement: huge start is accepted untouched.
    cfg_write(1, 16'hFFFF, 0, 2, 1);
    check("pre.pending", PENDING, 1);
    vs_to_commit();
    check("pre.commit_ready", CFG_READY, 0);
    check("pre.commit_pending", PENDING, 1);
    check("pre.hold_sx", CROP_START_X, 0);
    tick(1);
    check_crop("pre", 1, 65535, 0, 2, 1);
    check("pre.err", CFG_ERR, 0);
    check("pre.meas", MEAS_VALID, 0);
    check("pre.pending_off", PENDING, 0);

    // Mid-frame write, committed only in the next blanking.
    short_lines(500);
    cfg_write(1, 100, 50, 640, 480);
    check("mid.pending", PENDING, 1);
    check("mid.hold_sx", CROP_START_X, 65535);
    short_lines(579);
    long_line(1920);
    check("mid.hold_sx2", CROP_START_X, 65535);
    vs_to_commit();
    check("meas.fw", FRAME_WIDTH, 1920);
    check("meas.fh", FRAME_HEIGHT, 1080);
    check("meas.valid", MEAS_VALID, 1);
    check("mid.commit_hold", CROP_WIDTH, 2);
    tick(1);
    check_crop("mid", 1, 100, 50, 640, 480);
    check("mid.err", CFG_ERR, 0);

    // Two writes in one frame: last one wins.
    short_lines(300);
    cfg_write(1, 0, 0, 10, 10);
    check("two.pending1", PENDING, 1);
    short_lines(300);
    check("two.pending2", PENDING, 1);
    cfg_write(1, 8, 8, 16, 16);
    short_lines(479);
    long_line(1920);
    vs_to_commit();
    check("two.commit_pending", PENDING, 1);
    check("two.hold_sx", CROP_START_X, 100);
    tick(1);
    check_crop("two", 1, 8, 8, 16, 16);
    check("two.pending_off", PENDING, 0);

    // Write presented exactly on the vs_fall cycle.
    full_frame();
    VSYNC_POS_IN = 1'b1; tick(3);
    VSYNC_POS_IN = 1'b0;
    CFG_EN = 1'b1; CFG_START_X = 200; CFG_START_Y = 100; CFG_WIDTH = 320; CFG_HEIGHT = 240;
    CFG_VALID = 1'b1;
    check("vf.ready_before", CFG_READY, 1);
    tick(1);
    CFG_VALID = 1'b0;
    check("vf.commit_ready", CFG_READY, 0);
    check("vf.commit_pending", PENDING, 1);
    tick(1);
    check_crop("vf", 1, 200, 100, 320, 240);
    check("vf.ready_after", CFG_READY, 1);
    tick(1);
    check("vf.ready_after2", CFG_READY, 1);

    // Window runs past the right edge: reject or clamp, error pulse.
    short_lines(500);
    cfg_write(1, 1900, 0, 100, 10);
    short_lines(579);
    long_line(1920);
    vs_to_commit();
    check("oob.err_early", CFG_ERR, 0);
    tick(1);
    check("oob.err", CFG_ERR, 1);
    check_crop("oob", 1, E6_SX, E6_SY, E6_W, E6_H);
    tick(1);
    check("oob.err_clear", CFG_ERR, 0);

    // 65535 + 2 must not wrap into range once measurement is valid.
    cfg_write(1, 16'hFFFF, 0, 2, 10);
    full_frame();
    vs_to_commit();
    tick(1);
    check("wrap.err", CFG_ERR, 1);
    check_crop("wrap", 1, E7_SX, E7_SY, E7_W, E7_H);

    // Disabled window bypasses the range check.
    cfg_write(0, 5000, 0, 100, 10);
    full_frame();
    vs_to_commit();
    tick(1);
    check("dis.err", CFG_ERR, 0);
    check_crop("dis", 0, 5000, 0, 100, 10);

    // Reset while pending drops the shadow config.
    cfg_write(1, 1, 1, 1, 1);
    check("rp.pending", PENDING, 1);
    RST_N = 1'b0;
    tick(1);
    RST_N = 1'b1;
    check("rp.ready", CFG_READY, 0);
    check("rp.pending_off", PENDING, 0);
    check("rp.meas", MEAS_VALID, 0);
    check("rp.fh", FRAME_HEIGHT, 0);
    check_crop("rp", 0, 0, 0, 0, 0);
    tick(1);
    check("rp.ready_after", CFG_READY, 1);
    vs_to_commit();
    check("rp.no_commit", PENDING, 0);
    tick(1);
    check_crop("rp.post", 0, 0, 0, 0, 0);
    check("rp.err", CFG_ERR, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/crop_config_sched.md
CROP_CONFIG_SCHED -- requirements
Module: crop_config_sched

Interface
REQ-001 SHALL have port CLK  input  1  master clock; all logic on rising edge.
REQ-002 SHALL have port RST_N  input  1  reset, synchronous, active-low.
REQ-003 SHALL have ports DE_IN / VSYNC_POS_IN / HSYNC_POS_IN  input  1 each  video timing, monitored only; VSYNC active-high.
REQ-004 SHALL have ports CFG_VALID  input  1, and CFG_READY  output  1  config write handshake.
REQ-005 SHALL have ports CFG_EN  input  1, and CFG_START_X, CFG_START_Y, CFG_WIDTH, CFG_HEIGHT  input  16 each  requested crop window.
REQ-006 SHALL have ports CROP_EN  output  1, and CROP_START_X, CROP_START_Y, CROP_WIDTH, CROP_HEIGHT  output  16 each, all registered  drive the crop datapath.
REQ-007 SHALL have ports FRAME_WIDTH, FRAME_HEIGHT  output  16 each, and MEAS_VALID  output  1  measured active frame size.
REQ-008 SHALL have ports PENDING  output  1, and CFG_ERR  output  1  one-cycle reject/clamp pulse.

Function
REQ-009 SHALL register VSYNC_POS_IN into vs_prev; vs_fall = ~VSYNC_POS_IN & vs_prev; vs_rise = VSYNC_POS_IN & ~vs_prev.
REQ-010 SHALL count DE_IN-high cycles per line; on a DE falling edge, SHALL load FRAME_WIDTH with the count (inclusive of the last pixel) and clear the count.
REQ-011 SHALL count lines containing at least one DE cycle; on vs_rise, SHALL load FRAME_HEIGHT with the line count and clear it; MEAS_VALID SHALL set on the first vs_rise with nonzero line count and stay set.
REQ-012 SHALL run FSM states IDLE, PEND, COMMIT.
REQ-013 SHALL drive CFG_READY high in IDLE and PEND, and low in COMMIT and during reset.
REQ-014 SHALL capture CFG_* into shadow registers on CFG_VALID & CFG_READY; IDLE->PEND; in PEND a new write overwrites the shadow (last write wins).
REQ-015 SHALL take PEND->COMMIT on vs_fall; a write in the same cycle as vs_fall SHALL be captured and committed in that COMMIT.
REQ-016 In COMMIT (one cycle), SHALL compute end_x = START_X + WIDTH and end_y = START_Y + HEIGHT at 17 bits; the window is valid when MEAS_VALID=0, or end_x <= FRAME_WIDTH and end_y <= FRAME_HEIGHT.
REQ-017 A valid window SHALL load the CROP_* outputs from shadow at the COMMIT->IDLE edge, i.e. outputs change exactly 2 cycles after the first low VSYNC_POS_IN sample.
REQ-018 A window with CFG_EN=0 SHALL always be accepted (no range check) and load CROP_EN=0.
REQ-019 An invalid window SHALL be handled per REQ-025/026, with CFG_ERR high for exactly the COMMIT->IDLE cycle.
REQ-020 PENDING SHALL be high in PEND and COMMIT.
REQ-021 CROP_* outputs SHALL never change except at the COMMIT->IDLE edge, so that a frame never sees a partial update.

Reset
REQ-022 When RST_N=0 at a clock edge, SHALL clear all outputs and counters to 0 (CROP_EN=0, MEAS_VALID=0, CFG_READY=0) and enter IDLE.
REQ-023 A reset mid-PEND or mid-COMMIT SHALL discard the shadow config; no commit SHALL occur.
REQ-024 SHALL drive CFG_READY=1 on the first cycle after RST_N returns high.

Configuration
REQ-025 Without macro CROP_CLAMP_EN, an invalid window SHALL be rejected: CROP_* outputs keep their previous values.
REQ-026 With CROP_CLAMP_EN defined, an invalid window SHALL be accepted with each START clamped to min(START, FRAME-1) and each size clamped to FRAME - clamped START; CFG_ERR still pulses.

Verification
REQ-027 Reset then 1920x1080 timing, write (EN=1, 100, 50, 640, 480) mid-frame -> CROP_* unchanged until vs_fall; updated 2 cycles after it; FRAME_WIDTH=1920, FRAME_HEIGHT=1080.
REQ-028 Two writes in one frame, (0,0,10,10) then (8,8,16,16) -> only (8,8,16,16) committed; PENDING high from the first write until commit.
REQ-029 After measurement, write START_X=1900, WIDTH=100 -> CFG_ERR pulse; without macro CROP_* keep previous values; with CROP_CLAMP_EN, CROP_START_X=1900 and CROP_WIDTH=20.
REQ-030 Write with CFG_VALID asserted exactly on the vs_fall cycle -> write committed in the same blanking period; CFG_READY low for the COMMIT cycle only.
REQ-031 RST_N low for 1 cycle while PENDING=1 -> CROP_EN=0, MEAS_VALID=0, no commit at the next vs_fall.
REQ-032 Write with EN=1, START_X=65535, WIDTH=2 before MEAS_VALID -> accepted unchanged; end_x sum does not wrap in the range check.
